// File: rtl/piece_shifter.sv
// piece_shifter: horizontal movement controller for a falling piece.
//
// Tracks the column of a 4x4 piece footprint and moves it left/right from
// two level-sensitive buttons, with delayed auto-shift (DAS) followed by
// periodic auto-repeat (ARR). Each move attempt is checked combinationally
// against the board walls, floor and settled cells.
//
// Ports:
//   clk_i          clock, all state updates on rising edge
//   rst_ni         asynchronous active-low reset
//   spawn_i        pulse: new piece loaded, column returns to SPAWN_X
//   move_left_i    level: left button held
//   move_right_i   level: right button held
//   piece_mask_i   4x4 footprint [r][c], 1 = occupied
//   piece_row_i    board row of footprint row 0
//   board_occ_i    settled-cell occupancy [row][col]
//   piece_x_o      signed board column of footprint column 0
//   shifted_o      one-cycle pulse: a move was accepted
//   blocked_o      one-cycle pulse: a move attempt was rejected
module piece_shifter #(
  parameter int BOARD_W    = 10,
  parameter int BOARD_H    = 22,
  parameter int SPAWN_X    = 3,
  parameter int DAS_DELAY  = 16,
  parameter int ARR_PERIOD = 4,
  parameter int XW         = $clog2(BOARD_W) + 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              spawn_i,
  input  logic                              move_left_i,
  input  logic                              move_right_i,
  input  logic [3:0][3:0]                   piece_mask_i,
  input  logic [$clog2(BOARD_H)-1:0]        piece_row_i,
  input  logic [BOARD_H-1:0][BOARD_W-1:0]   board_occ_i,
  output logic signed [XW-1:0]              piece_x_o,
  output logic                              shifted_o,
  output logic                              blocked_o
);

  localparam int RW   = $clog2(BOARD_H);
  localparam int CW   = $clog2(BOARD_W);
  localparam int CMAX = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
  localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CNTW-1:0]      DAS_LOAD = CNTW'(DAS_DELAY - 1);
  localparam logic [CNTW-1:0]      ARR_LOAD = CNTW'(ARR_PERIOD - 1);
  localparam logic signed [XW-1:0] SPAWN_XV = XW'(SPAWN_X);

  typedef enum logic [1:0] {IDLE, DAS, REPEAT} state_e;

  state_e                state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  dir_q, dir_d;      // 1 = right
  logic signed [XW-1:0]  piece_x_q, piece_x_d;
  logic                  shifted_q, shifted_d;
  logic                  blocked_q, blocked_d;

  logic                  one_btn;
  logic                  attempt;
  logic signed [XW-1:0]  cand_x;
  logic [15:0]           cell_ok;
  logic                  legal;

  assign one_btn = move_left_i ^ move_right_i;

  // Every attempt is made in the currently held direction, so the candidate
  // only depends on move_right_i.
  assign cand_x = move_right_i ? piece_x_q + XW'(1) : piece_x_q - XW'(1);

  // Per-cell legality of the candidate position. Columns are widened by two
  // bits so a negative column is seen as negative rather than wrapping.
  for (genvar gi = 0; gi < 16; gi++) begin : g_cell
    localparam int R = gi / 4;
    localparam int C = gi % 4;
    localparam logic signed [XW+1:0] COL_LIM = (XW+2)'(BOARD_W);
    localparam logic [RW+1:0]        ROW_LIM = (RW+2)'(BOARD_H);

    logic signed [XW+1:0] col;
    logic [RW+1:0]        row;
    logic                 in_range;

    assign col      = {{2{cand_x[XW-1]}}, cand_x} + (XW+2)'(C);
    assign row      = {2'b00, piece_row_i} + (RW+2)'(R);
    assign in_range = !col[XW+1] && (col < COL_LIM) && (row < ROW_LIM);
    // The occupancy lookup is only trusted when the cell is in range.
    assign cell_ok[gi] = !piece_mask_i[R][C] ||
                         (in_range && !board_occ_i[row[RW-1:0]][col[CW-1:0]]);
  end

  assign legal = &cell_ok;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      piece_x_q <= SPAWN_XV;
      shifted_q <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      piece_x_q <= piece_x_d;
      shifted_q <= shifted_d;
      blocked_q <= blocked_d;
    end
  end

  // Next-state logic: DAS/ARR timing and attempt generation. A reversal in
  // DAS or REPEAT is handled exactly like a fresh press from IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    attempt = 1'b0;
    if (spawn_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (one_btn) begin
            attempt = 1'b1;
            dir_d   = move_right_i;
            cnt_d   = DAS_LOAD;
            state_d = DAS;
          end
        end
        DAS, REPEAT: begin
          if (!one_btn) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (move_right_i != dir_q) begin
            attempt = 1'b1;
            dir_d   = move_right_i;
            cnt_d   = DAS_LOAD;
            state_d = DAS;
          end else if (cnt_q == '0) begin
            attempt = 1'b1;
            cnt_d   = ARR_LOAD;
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_q - CNTW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic: resolve the attempt against the legality check.
  always_comb begin
    piece_x_d = piece_x_q;
    shifted_d = 1'b0;
    blocked_d = 1'b0;
    if (spawn_i) begin
      piece_x_d = SPAWN_XV;
    end else if (attempt) begin
      if (legal) begin
        piece_x_d = cand_x;
        shifted_d = 1'b1;
      end else begin
        blocked_d = 1'b1;
      end
    end
  end

  assign piece_x_o = piece_x_q;
  assign shifted_o = shifted_q;
  assign blocked_o = blocked_q;

endmodule

// File: tb/tb_piece_shifter.sv
// Directed testbench for piece_shifter with default parameters.
module tb_piece_shifter;

  logic                clk;
  logic                rst_n;
  logic                spawn;
  logic                move_left;
  logic                move_right;
  logic [3:0][3:0]     piece_mask;
  logic [4:0]          piece_row;
  logic [21:0][9:0]    board_occ;
  logic signed [5:0]   piece_x;
  logic                shifted;
  logic                blocked;

  int n_total = 0;
  int n_pass  = 0;
  int sh_cnt  = 0;
  int bl_cnt  = 0;
  int both_cnt = 0;

  piece_shifter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .spawn_i      (spawn),
    .move_left_i  (move_left),
    .move_right_i (move_right),
    .piece_mask_i (piece_mask),
    .piece_row_i  (piece_row),
    .board_occ_i  (board_occ),
    .piece_x_o    (piece_x),
    .shifted_o    (shifted),
    .blocked_o    (blocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (shifted) sh_cnt = sh_cnt + 1;
      if (blocked) bl_cnt = bl_cnt + 1;
      if (shifted && blocked) both_cnt = both_cnt + 1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_total = n_total + 1;
    if (obs == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_o_piece();
    piece_mask    = '0;
    piece_mask[0] = 4'b0110;
    piece_mask[1] = 4'b0110;
  endtask

  task automatic set_i_piece();
    piece_mask    = '0;
    piece_mask[0] = 4'b1111;
  endtask

  task automatic do_spawn();
    spawn = 1'b1;
    tick();
    spawn = 1'b0;
  endtask

  int exp_x;
  int exp_sh;
  int exp_bl;
  int x_hold;

  initial begin
    rst_n      = 1'b1;
    spawn      = 1'b0;
    move_left  = 1'b0;
    move_right = 1'b0;
    piece_row  = 5'd5;
    board_occ  = '0;
    set_o_piece();

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("reset_x", int'(piece_x), 3);
    check("reset_shifted", int'(shifted), 0);
    check("reset_blocked", int'(blocked), 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Tap left once on an empty board.
    do_spawn();
    check("tap_spawn_x", int'(piece_x), 3);
    move_left = 1'b1;
    tick();
    check("tap_x", int'(piece_x), 2);
    check("tap_shifted", int'(shifted), 1);
    check("tap_blocked", int'(blocked), 0);
    move_left = 1'b0;
    tick();
    check("tap_shifted_drop", int'(shifted), 0);
    sh_cnt = 0; bl_cnt = 0;
    ticks(30);
    check("tap_no_more_moves", sh_cnt + bl_cnt, 0);
    check("tap_x_final", int'(piece_x), 2);

    // Hold right 40 cycles with a horizontal I-piece.
    set_i_piece();
    do_spawn();
    check("hold_spawn_x", int'(piece_x), 3);
    move_right = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      exp_x  = (k < 16) ? 4 : ((k < 20) ? 5 : 6);
      exp_sh = (k == 0 || k == 16 || k == 20) ? 1 : 0;
      exp_bl = (k >= 24 && (k % 4) == 0) ? 1 : 0;
      check($sformatf("hold_x[%0d]", k), int'(piece_x), exp_x);
      check($sformatf("hold_sh[%0d]", k), int'(shifted), exp_sh);
      check($sformatf("hold_bl[%0d]", k), int'(blocked), exp_bl);
    end
    move_right = 1'b0;
    tick();

    // Left blocked by a settled cell in column 2.
    set_o_piece();
    do_spawn();
    move_left = 1'b1;
    tick();
    move_left = 1'b0;
    tick();
    check("obst_setup_x", int'(piece_x), 2);
    board_occ[5][2] = 1'b1;
    move_left = 1'b1;
    tick();
    check("obst_x", int'(piece_x), 2);
    check("obst_blocked", int'(blocked), 1);
    check("obst_shifted", int'(shifted), 0);
    move_left = 1'b0;
    tick();
    check("obst_blocked_drop", int'(blocked), 0);
    board_occ = '0;

    // Left 10 cycles, then reverse to right: new press, fresh DAS.
    do_spawn();
    for (int k = 0; k < 27; k++) begin
      move_left  = (k < 10);
      move_right = (k >= 10);
      tick();
      exp_x  = (k < 10) ? 2 : ((k < 26) ? 3 : 4);
      exp_sh = (k == 0 || k == 10 || k == 26) ? 1 : 0;
      check($sformatf("rev_x[%0d]", k), int'(piece_x), exp_x);
      check($sformatf("rev_sh[%0d]", k), int'(shifted), exp_sh);
      check($sformatf("rev_bl[%0d]", k), int'(blocked), 0);
    end
    move_right = 1'b0;
    ticks(2);

    // Both buttons held: no attempts at all.
    x_hold = int'(piece_x);
    sh_cnt = 0; bl_cnt = 0;
    move_left  = 1'b1;
    move_right = 1'b1;
    ticks(20);
    check("both_pulses", sh_cnt + bl_cnt, 0);
    check("both_x", int'(piece_x), x_hold);
    move_left  = 1'b0;
    move_right = 1'b0;
    tick();

    // Spawn during a right hold: next cycle is a fresh press.
    do_spawn();
    move_right = 1'b1;
    tick();
    check("spawnhold_first_x", int'(piece_x), 4);
    ticks(5);
    spawn = 1'b1;
    tick();
    spawn = 1'b0;
    check("spawnhold_x", int'(piece_x), 3);
    check("spawnhold_shifted", int'(shifted), 0);
    check("spawnhold_blocked", int'(blocked), 0);
    tick();
    check("spawnhold_repress_x", int'(piece_x), 4);
    check("spawnhold_repress_sh", int'(shifted), 1);
    move_right = 1'b0;
    ticks(2);

    // Reset asserted mid-REPEAT acts without a clock edge.
    do_spawn();
    move_right = 1'b1;
    ticks(21);
    check("rep_x_before_reset", int'(piece_x), 6);
    check("rep_sh_before_reset", int'(shifted), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_x", int'(piece_x), 3);
    check("async_reset_shifted", int'(shifted), 0);
    check("async_reset_blocked", int'(blocked), 0);
    rst_n = 1'b1;
    tick();
    check("post_reset_press_x", int'(piece_x), 4);
    check("post_reset_press_sh", int'(shifted), 1);
    move_right = 1'b0;
    ticks(2);

    check("never_both_pulses", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/piece_shifter.md
PIECE_SHIFTER -- requirements
Module: piece_shifter

Interface
REQ-001 The module SHALL have parameter BOARD_W, default 10, board width in columns.
REQ-002 The module SHALL have parameter BOARD_H, default 22, board height in rows.
REQ-003 The module SHALL have parameter SPAWN_X, default 3, column of the footprint's left edge at spawn.
REQ-004 The module SHALL have parameter DAS_DELAY, default 16, the number of cycles a direction is held before auto-repeat starts (>=1).
REQ-005 The module SHALL have parameter ARR_PERIOD, default 4, the number of cycles between auto-repeat steps (>=1).
REQ-006 The module SHALL have parameter XW, default $clog2(BOARD_W)+2, the signed width of piece_x.
REQ-007 clk  input  1  single clock; all state updates on its rising edge.
REQ-008 rst_n  input  1  reset, asynchronous and active-low.
REQ-009 spawn  input  1  pulse: a new piece is loaded this cycle.
REQ-010 move_left  input  1  level: left button held.
REQ-011 move_right  input  1  level: right button held.
REQ-012 piece_mask  input  [3:0][3:0]  4x4 footprint [r][c]; 1 = occupied cell.
REQ-013 piece_row  input  [$clog2(BOARD_H)-1:0]  board row of footprint row 0.
REQ-014 board_occ  input  [BOARD_H-1:0][BOARD_W-1:0]  settled-cell occupancy.
REQ-015 piece_x  output  XW signed  board column of footprint column 0.
REQ-016 shifted  output  1  one-cycle pulse: piece_x changed by a move.
REQ-017 blocked  output  1  one-cycle pulse: a move attempt was rejected.

Function
REQ-018 Footprint cell [r][c] SHALL map to board cell (piece_row+r, piece_x+c).
REQ-019 A candidate position SHALL be legal only if every set mask cell maps to a column in 0..BOARD_W-1 and a row in 0..BOARD_H-1, and no set cell overlaps a 1 in board_occ.
REQ-020 The legality check SHALL be combinational on the current inputs and piece_x+dir, with dir = -1 for left and +1 for right.
REQ-021 On an attempt, a legal candidate SHALL load piece_x at that edge and set shifted for the next cycle; an illegal candidate SHALL leave piece_x unchanged and set blocked for the next cycle.
REQ-022 The FSM SHALL have the states IDLE, DAS and REPEAT, and a registered last-direction bit.
REQ-023 In IDLE, with exactly one button held, the module SHALL attempt a move, load the DAS counter with DAS_DELAY-1, and go to DAS.
REQ-024 In DAS, while the same single direction is held, the counter SHALL decrement; at 0 the module SHALL attempt a move, load the counter with ARR_PERIOD-1, and go to REPEAT.
REQ-025 In REPEAT, while the same direction is held, the counter SHALL decrement; at 0 the module SHALL attempt a move and reload ARR_PERIOD-1.
REQ-026 In DAS or REPEAT, if no button or both buttons are held, the FSM SHALL go to IDLE with no attempt.
REQ-027 In DAS or REPEAT, if the held direction reverses, the module SHALL behave exactly as an IDLE press in the new direction in the same cycle.
REQ-028 In IDLE, if both buttons are held, no attempt SHALL be made.
REQ-029 A blocked attempt SHALL NOT alter FSM timing; the counters SHALL continue and later attempts SHALL re-evaluate.
REQ-030 spawn SHALL take priority: piece_x <= SPAWN_X, FSM <= IDLE, no attempt that cycle, and shifted and blocked low next cycle.
REQ-031 A direction held through spawn SHALL be treated as a new press on the following cycle.
REQ-032 shifted and blocked SHALL never be high in the same cycle.

Reset
REQ-033 While rst_n=0, asynchronously: piece_x = SPAWN_X, FSM = IDLE, counter = 0, shifted = 0, blocked = 0.
REQ-034 Reset deasserted mid-hold SHALL restart from IDLE; a still-held button counts as a new press.

Verification
REQ-035 Empty board, O-piece mask cols 1-2, spawn, then tap left for 1 cycle -> piece_x 3->2, shifted pulses once, no further moves.
REQ-036 Hold right for 40 cycles (defaults, I-piece horizontal, mask row 0 cols 0-3, piece_x=3) -> moves at cycle 0 and 16, then every 4 cycles until piece_x=6; subsequent attempts pulse blocked.
REQ-037 board_occ column 2 set in piece_row, O-piece at piece_x=2 (cells in cols 3-4), press left -> piece_x stays 2, blocked=1 for one cycle.
REQ-038 Hold left 10 cycles, then switch to right -> immediate right attempt, new 16-cycle DAS, no left repeat.
REQ-039 Both buttons held 20 cycles -> no shifted or blocked pulses; spawn during a right hold -> piece_x=3, right move attempted the next cycle.
REQ-040 rst_n low mid-REPEAT -> all outputs at reset values immediately without a clock edge.
